// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer: FSM encoding,
// shift directions and the datapath/length limits.
package shift_sequencer_pkg;

   localparam int WIDTH   = 8;
   localparam int LEN_W   = 4;
   localparam int MAX_LEN = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Requests longer than the register width would only shift in ser_in again.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
      return (req > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req;
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command handshake, serial stream and completion signals of the sequencer.
interface shift_sequencer_if;
   import shift_sequencer_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_dir;
   logic [LEN_W-1:0] cmd_len;
   logic             ser_in;
   logic             bit_valid;
   logic             bit_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output cmd_valid, cmd_data, cmd_dir, cmd_len, ser_in,
      input  cmd_ready, bit_valid, bit_out, busy, done, result
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_dir, cmd_len, ser_in,
      output cmd_ready, bit_valid, bit_out, busy, done, result
   );

endinterface

// File: rtl/shift_sequencer_shift_register.sv
// 8-bit load/shift register: mode=1 loads, mode=0 with en shifts one place
// in the selected direction, otherwise the contents hold.
module shift_register
   import shift_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             en,
   input  logic             dir,
   input  logic             serialIn,
   input  logic [WIDTH-1:0] parallelIn,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;

   // Each bit takes its neighbour; the vacated end takes serialIn.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign shl[gi] = serialIn;
            assign shr[gi] = state_q[gi+1];
         end else if (gi == WIDTH-1) begin : g_msb
            assign shl[gi] = state_q[gi-1];
            assign shr[gi] = serialIn;
         end else begin : g_mid
            assign shl[gi] = state_q[gi-1];
            assign shr[gi] = state_q[gi+1];
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      if (mode) begin
         state_d = parallelIn;
      end else if (en) begin
         state_d = (dir == DIR_LEFT) ? shl : shr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/shift_sequencer.sv
// Accepts one load-then-shift command, drives the shift register through
// LOAD/SHIFT/DONE, streams departing bits and reports the final contents.
module shift_sequencer
   import shift_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   shift_sequencer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic             sr_mode;
   logic             sr_en;
   logic [WIDTH-1:0] sr_state;

   shift_register u_sr (
      .clk        (clk),
      .reset      (reset),
      .mode       (sr_mode),
      .en         (sr_en),
      .dir        (dir_q),
      .serialIn   (bus.ser_in),
      .parallelIn (data_q),
      .state      (sr_state)
   );

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      dir_d         = dir_q;
      data_d        = data_q;
      sr_mode       = 1'b0;
      sr_en         = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.busy      = 1'b1;
      bus.done      = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_out   = 1'b0;
      bus.result    = '0;

      case (state_q)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            bus.busy      = 1'b0;
            if (bus.cmd_valid) begin
               data_d  = bus.cmd_data;
               dir_d   = bus.cmd_dir;
               len_d   = clamp_len(bus.cmd_len);
               state_d = LOAD;
            end
         end
         LOAD: begin
            sr_mode = 1'b1;
            state_d = (len_q == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            sr_en         = 1'b1;
            bus.bit_valid = 1'b1;
            bus.bit_out   = (dir_q == DIR_LEFT) ? sr_state[WIDTH-1] : sr_state[0];
            len_d         = len_q - LEN_W'(1);
            // The <= guard keeps a corrupted zero count from wrapping to 15 shifts.
            if (len_q <= LEN_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.done   = 1'b1;
            bus.result = sr_state;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         dir_q   <= DIR_RIGHT;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         dir_q   <= dir_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset state, four shift commands,
// held cmd_valid across two commands, and reset abort mid-shift.
module tb_shift_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   shift_sequencer_if bus ();

   shift_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and watch the busy period until done (bounded).
   task automatic run_cmd(input string tag, input logic [7:0] data, input logic dir,
                          input logic [3:0] len, input logic sin,
                          output int nbits, output logic [15:0] bits,
                          output int done_cyc, output logic [7:0] res, output logic stray);
      bus.cmd_data  = data;
      bus.cmd_dir   = dir;
      bus.cmd_len   = len;
      bus.ser_in    = sin;
      bus.cmd_valid = 1'b1;
      chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = ~data;
      bus.cmd_dir   = ~dir;
      bus.cmd_len   = 4'd0;
      nbits = 0; bits = '0; done_cyc = 0; res = '0; stray = 1'b0;
      for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
         if (bus.bit_valid) begin
            if (nbits < 16) bits[nbits] = bus.bit_out;
            nbits++;
         end else if (bus.bit_out !== 1'b0) begin
            stray = 1'b1;
         end
         if (!bus.done && bus.result !== 8'h00) stray = 1'b1;
         if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) stray = 1'b1;
         if (bus.done) begin
            done_cyc = c;
            res      = bus.result;
         end
         tick();
      end
   endtask

   initial begin
      int          nbits, done_cyc, done_cnt;
      logic [15:0] bits, rdy_hist, done_hist;
      logic [7:0]  res, res1, res2;
      logic        stray;

      reset = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_dir = 1'b0;
      bus.cmd_len = '0; bus.ser_in = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_ready",     32'(bus.cmd_ready), 32'd1);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_done",      32'(bus.done),      32'd0);
      chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
      chk("rst_bit_out",   32'(bus.bit_out),   32'd0);
      chk("rst_result",    32'(bus.result),    32'h00);

      run_cmd("t1", 8'h09, 1'b0, 4'd8, 1'b0, nbits, bits, done_cyc, res, stray);
      chk("t1_nbits", nbits, 8);
      chk("t1_bits", 32'(bits), 'h0009);
      chk("t1_done_cyc", done_cyc, 10);
      chk("t1_result", 32'(res), 'h00);
      chk("t1_quiet", 32'(stray), 0);

      run_cmd("t2", 8'h1C, 1'b1, 4'd3, 1'b1, nbits, bits, done_cyc, res, stray);
      chk("t2_nbits", nbits, 3);
      chk("t2_bits", 32'(bits), 'h0000);
      chk("t2_done_cyc", done_cyc, 5);
      chk("t2_result", 32'(res), 'hE7);
      chk("t2_quiet", 32'(stray), 0);

      run_cmd("t3", 8'hA5, 1'b0, 4'd0, 1'b1, nbits, bits, done_cyc, res, stray);
      chk("t3_nbits", nbits, 0);
      chk("t3_done_cyc", done_cyc, 2);
      chk("t3_result", 32'(res), 'hA5);
      chk("t3_quiet", 32'(stray), 0);

      run_cmd("t4", 8'hFF, 1'b0, 4'd12, 1'b0, nbits, bits, done_cyc, res, stray);
      chk("t4_nbits", nbits, 8);
      chk("t4_bits", 32'(bits), 'h00FF);
      chk("t4_done_cyc", done_cyc, 10);
      chk("t4_result", 32'(res), 'h00);
      chk("t4_quiet", 32'(stray), 0);

      // cmd_valid held high: 0x0F >> 1 then 0x80 with len 0.
      bus.cmd_data = 8'h0F; bus.cmd_dir = 1'b0; bus.cmd_len = 4'd1;
      bus.ser_in = 1'b0; bus.cmd_valid = 1'b1;
      rdy_hist = '0; done_hist = '0; res1 = '0; res2 = '0;
      for (int c = 0; c <= 8; c++) begin
         rdy_hist[c]  = bus.cmd_ready;
         done_hist[c] = bus.done;
         if (c == 3) res1 = bus.result;
         if (c == 6) res2 = bus.result;
         if (c == 1) begin bus.cmd_data = 8'h80; bus.cmd_len = 4'd0; end
         if (c == 5) bus.cmd_valid = 1'b0;
         tick();
      end
      chk("ovl_ready_hist", 32'(rdy_hist), 'h0191);
      chk("ovl_done_hist", 32'(done_hist), 'h0048);
      chk("ovl_result1", 32'(res1), 'h07);
      chk("ovl_result2", 32'(res2), 'h80);

      // Reset on the third SHIFT cycle of a len=8 command.
      bus.cmd_data = 8'hF0; bus.cmd_dir = 1'b0; bus.cmd_len = 4'd8;
      bus.ser_in = 1'b1; bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick(); tick(); tick();
      chk("abort_in_shift", 32'(bus.bit_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_ready",     32'(bus.cmd_ready), 32'd1);
      chk("abort_busy",      32'(bus.busy),      32'd0);
      chk("abort_done",      32'(bus.done),      32'd0);
      chk("abort_result",    32'(bus.result),    32'h00);
      chk("abort_bit_valid", 32'(bus.bit_valid), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.done) done_cnt++;
         tick();
      end
      chk("abort_no_done", done_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller that sequences an 8-bit shift_register through load-then-shift operations.
- Accepts one command (data, direction, shift length) over a valid/ready handshake.
- Drives the shift register's load/shift mode and direction, and streams the departing bits with a per-bit valid.
- Returns the final register contents with a one-cycle done pulse; sits between the control logic and the serial datapath.

Parameters:
- WIDTH, 8: data width; fixed by shift_register, must stay 8.
- LEN_W, 4: width of cmd_len.
- MAX_LEN, 8: largest shift count honoured; larger requests are clamped.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_data  input  8  value loaded into the shift register.
- cmd_dir  input  1  0 = shift right, 1 = shift left.
- cmd_len  input  LEN_W  number of shifts requested (0..15).
- ser_in  input  1  bit shifted into the vacated end during SHIFT.
- bit_valid  output  1  high on each SHIFT cycle.
- bit_out  output  1  bit leaving the register this cycle.
- busy  output  1  high in LOAD, SHIFT and DONE.
- done  output  1  one-cycle pulse in DONE.
- result  output  8  shift register contents; valid while done=1.

Behaviour:
- Reset: state=IDLE, internal shift_register cleared to 0x00, len counter 0, captured dir 0.
  - Outputs after reset: cmd_ready=1, busy=0, done=0, bit_valid=0, bit_out=0, result=0x00.
  - Reset mid-operation aborts the current command immediately. No done pulse is produced for the aborted command.
- Sub-module contract (shift_register):
  - mode=1: load parallelIn.
  - mode=0, dir=0: state <= {serialIn, state[7:1]}.
  - mode=0, dir=1: state <= {state[6:0], serialIn}.
  - The internal shift_register's reset is driven by the block's reset.
- IDLE:
  - cmd_ready=1; shift_register mode=0 with shifting suppressed, so state holds.
  - Handshake completes on cmd_valid & cmd_ready at a rising edge. At that edge: capture cmd_data and cmd_dir, and set len = min(cmd_len, MAX_LEN).
  - Next state: LOAD.
- LOAD (1 cycle):
  - Drive mode=1, parallelIn=captured data.
  - Next state: SHIFT if len>0, otherwise DONE.
- SHIFT (len cycles):
  - Drive mode=0, dir=captured dir, serialIn=ser_in; assert bit_valid=1.
  - bit_out = state[0] when dir=0, state[7] when dir=1 (combinational from the current state, before the edge).
  - Decrement len each cycle; when len reaches 1 at the edge, go to DONE.
- DONE (1 cycle):
  - done=1, result=state. No shift occurs.
  - Next state: IDLE.
- Latency: handshake edge to done = len+2 cycles; len=0 gives 2 cycles.
- Command rules:
  - cmd_valid held high while busy is ignored; it is accepted on the first IDLE cycle.
  - Back-to-back commands: one IDLE cycle minimum between a done pulse and the next acceptance.
- Output values outside their active state: bit_out=0 when bit_valid=0; result=0x00 outside DONE.
- Changes to cmd_* after acceptance have no effect on the running command.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3;
  - DIR_RIGHT=1'b0, DIR_LEFT=1'b1;
  - WIDTH and MAX_LEN constants.
- One sub-module: the existing shift_register, instantiated once. The FSM and length counter live in shift_sequencer.

Test Plan:
- Reset, then cmd_data=0x09, dir=0, len=8, ser_in=0.
  - bit_out over 8 SHIFT cycles = 1,0,0,1,0,0,0,0.
  - done exactly 10 cycles after the handshake edge, result=0x00.
- cmd_data=0x1C, dir=1, len=3, ser_in=1.
  - bit_out = 0,0,0; register passes 0x39, 0x73.
  - done with result=0xE7 at handshake+5.
- cmd_data=0xA5, len=0.
  - No bit_valid pulses; done at handshake+2, result=0xA5.
- cmd_data=0xFF, dir=0, len=12, ser_in=0.
  - Clamped: exactly 8 bit_valid cycles, all bit_out=1; result=0x00.
- Overlapping commands: cmd_valid held high for two commands.
  - cmd_ready=0 throughout busy; second command accepted only on the IDLE cycle after done.
- Assert reset on the 3rd SHIFT cycle of a len=8 command.
  - Next cycle: IDLE, cmd_ready=1, result=0x00, no done pulse.
